// File: rtl/conv_maxpool2x2_pkg.sv
// conv_maxpool2x2_pkg: shared defaults, FSM encoding and counter sizing for conv_maxpool2x2
package conv_maxpool2x2_pkg;
    localparam int DATA_W_DEF = 9;
    localparam int FM_W_DEF = 6;
    localparam int FM_H_DEF = 6;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    localparam int POOL_W = FM_W_DEF / 2;
    localparam int COL_W = cnt_w(FM_W_DEF);
    localparam int ROW_W = cnt_w(FM_H_DEF);
endpackage

// File: rtl/conv_maxpool2x2_if.sv
// conv_maxpool2x2_if: frame control, sample stream and pooled output stream of the pooling stage
interface conv_maxpool2x2_if #(
    parameter int DATA_W = conv_maxpool2x2_pkg::DATA_W_DEF
);
    logic start, in_valid, out_valid, done, busy;
    logic [DATA_W-1:0] in_data, out_data;
    modport master(output start, in_valid, in_data, input out_valid, out_data, done, busy);
    modport slave(input start, in_valid, in_data, output out_valid, out_data, done, busy);
endinterface

// File: rtl/conv_maxpool2x2_pool_line_buf.sv
// conv_maxpool2x2_pool_line_buf: half-width line of pair maxima, one shared index, combinational read
module conv_maxpool2x2_pool_line_buf #(
    parameter int DATA_W = 9,
    parameter int DEPTH = 3,
    parameter int IDX_W = 2
) (
    input  logic              clock,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    // even rows deposit pair maxima; contents need no reset since they are rewritten before use
    always_ff @(posedge clock) begin
        if (we) mem[idx] <= wdata;
    end
    assign rdata = mem[idx];
endmodule

// File: rtl/conv_maxpool2x2.sv
// conv_maxpool2x2: 2x2 stride-2 max pooling of the raster-ordered convolver stream
// Optional: define CONV_MAXPOOL_RELU_EN for signed input clamped at zero before comparison
module conv_maxpool2x2
    import conv_maxpool2x2_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FM_W = FM_W_DEF,
    parameter int FM_H = FM_H_DEF
) (
    input logic clock,
    input logic reset,
    conv_maxpool2x2_if.slave bus
);
    localparam int PW = FM_W / 2;
    localparam int CW = cnt_w(FM_W);
    localparam int RW = cnt_w(FM_H);
    localparam int IW = cnt_w(PW);
    logic [1:0] state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DATA_W-1:0] pair, sample, pair_max, line_rd, pool_max, pool_data;
    logic [IW-1:0] idx;
    logic accept, last_col, last_row, complete, pool_valid;
    // a start pulse always wins over a sample arriving in the same cycle
    assign accept = state == RUN && bus.in_valid && !bus.start;
    assign last_col = col == CW'(FM_W - 1);
    assign last_row = row == RW'(FM_H - 1);
    assign complete = accept && col[0] && row[0];
    assign idx = IW'(col >> 1);
`ifdef CONV_MAXPOOL_RELU_EN
    assign sample = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
    assign pair_max = $signed(pair) > $signed(sample) ? pair : sample;
    assign pool_max = $signed(line_rd) > $signed(pair_max) ? line_rd : pair_max;
`else
    assign sample = bus.in_data;
    assign pair_max = pair > sample ? pair : sample;
    assign pool_max = line_rd > pair_max ? line_rd : pair_max;
`endif
    conv_maxpool2x2_pool_line_buf #(.DATA_W(DATA_W), .DEPTH(PW), .IDX_W(IW)) pool_line_buf (
        .clock(clock),
        .we(accept && col[0] && !row[0]),
        .idx(idx),
        .wdata(pair_max),
        .rdata(line_rd)
    );
    // frame FSM, raster counters and the even-column pair register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            col <= '0;
            row <= '0;
            pair <= '0;
        end else if (bus.start) begin
            state <= RUN;
            col <= '0;
            row <= '0;
            pair <= '0;
        end else if (state == FLUSH) begin
            state <= IDLE;
        end else if (accept) begin
            if (!col[0]) pair <= sample;
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) row <= last_row ? '0 : row + 1'b1;
            if (last_col && last_row) state <= FLUSH;
        end
    end
    // registered pooled result, one cycle behind the window-completing sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pool_valid <= 1'b0;
            pool_data <= '0;
        end else begin
            pool_valid <= complete;
            if (complete) pool_data <= pool_max;
        end
    end
    assign bus.out_valid = pool_valid;
    assign bus.out_data = pool_data;
    assign bus.done = state == FLUSH && !bus.start;
    assign bus.busy = state == RUN;
endmodule
